spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, named and ordered as follows.
REQ-002 clk_i  input  1  system clock, all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 spi_byte_data_i  input  8  next byte to transmit on MISO, supplied by the consumer.
REQ-005 spi_sclk_i  input  1  SPI clock, asynchronous to clk_i.
REQ-006 spi_mosi_i  input  1  SPI master-out data, asynchronous.
REQ-007 spi_cs_n_i  input  1  SPI chip select, active low, asynchronous.
REQ-008 spi_miso_o  output  1  SPI master-in data, always driven (no tri-state).
REQ-009 spi_byte_vld_o  output  1  one-clk_i pulse marking a received byte.
REQ-010 spi_byte_data_o  output  8  last received byte, held until the next byte completes.

Function
REQ-011 The protocol SHALL be SPI mode 0: CPOL=0, CPHA=0, MSB first, MOSI sampled on the SCLK rising edge, MISO changed on the SCLK falling edge.
REQ-012 Each of sclk, mosi and cs_n SHALL pass through a 2-flop synchronizer, followed by one extra stage for edge detection on sclk and cs_n.
REQ-013 On each synchronized SCLK rise with cs_n low, the module SHALL shift mosi into the rx register LSB side and increment a 3-bit bit counter.
REQ-014 When the 8th bit is sampled (counter wraps 7->0), the module SHALL update spi_byte_data_o and pulse spi_byte_vld_o high for exactly one clk_i cycle.
REQ-015 spi_byte_vld_o SHALL rise no later than 4 clk_i cycles after the SCLK rising edge.
REQ-016 The bit counter SHALL wrap continuously, so back-to-back bytes need no cs_n toggle.
REQ-017 A synchronized cs_n falling edge SHALL load spi_byte_data_i into the tx register and drive its bit 7 onto spi_miso_o.
REQ-018 On each SCLK fall with cs_n low, spi_miso_o SHALL present the next tx bit.
REQ-019 On the SCLK fall that follows a completed byte, the module SHALL reload the tx register from spi_byte_data_i, so a value updated in response to spi_byte_vld_o is sent as the next byte.
REQ-020 While cs_n is high, the bit counter SHALL be held at 0, a partial byte SHALL be discarded without asserting vld, and SCLK/MOSI SHALL be ignored.
REQ-021 A cs_n rise mid-byte SHALL abort the byte, and the next cs_n fall SHALL start a fresh byte at bit 7.
REQ-022 SCLK high and low times SHALL each be at least 3 clk_i periods; behaviour at faster SCLK rates is unspecified.

Reset
REQ-023 While rst_i is high, spi_byte_vld_o SHALL be 0, spi_byte_data_o 0x00, spi_miso_o 0, counters 0, and synchronizers at idle (sclk 0, mosi 0, cs_n 1).
REQ-024 Reset asserted mid-byte SHALL discard the partial byte, and no vld SHALL be generated for it after release.

Configuration
REQ-025 With macro SPI_SLAVE_MISO_EN defined, the tx path SHALL be implemented as in REQ-017 to REQ-019.
REQ-026 Without SPI_SLAVE_MISO_EN, spi_miso_o SHALL be tied to 0, spi_byte_data_i SHALL be unused, and no tx logic SHALL be synthesized; the rx path is unchanged.

Verification
REQ-027 clk_i 200 MHz, SCLK period 30 ns, cs_n low, MOSI 0x2A then 0x2B -> two vld pulses with data 0x2A then 0x2B.
REQ-028 The same frame followed by 1024 zero bits -> 128 further vld pulses, each with data 0x00, and no vld after cs_n rises.
REQ-029 MISO_EN defined, spi_byte_data_i = 0x6E and incremented by the bench on each vld -> MISO carries 0x6E, 0x6F, 0x70, ... MSB first.
REQ-030 cs_n deasserted after 5 bits, then a full 0xA5 byte -> exactly one vld, data 0xA5.
REQ-031 rst_i pulsed after 4 bits of 0xFF, then a full 0x3C byte -> outputs at reset values during reset, then one vld with data 0x3C.
REQ-032 MISO_EN undefined, any traffic -> spi_miso_o constantly 0 and rx results identical to REQ-027.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled on clk_i, byte-wide rx with a one-cycle valid strobe.
// Define SPI_SLAVE_MISO_EN to build the MISO transmit path; otherwise MISO is tied low.
`timescale 1ns/1ps

module spi_slave (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] spi_byte_data_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_n_i,
    output logic       spi_miso_o,
    output logic       spi_byte_vld_o,
    output logic [7:0] spi_byte_data_o
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W);

    logic              sclk_p0, sclk_p1, sclk_p2;
    logic              cs_n_p0, cs_n_p1, cs_n_p2;
    logic              mosi_p0, mosi_p1;
    logic              sclk_rise, sclk_fall, cs_fall, cs_act;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_byte;

    // Stage p0/p1: two-flop synchronizers; p2: delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
        end else begin
            sclk_p0 <= spi_sclk_i;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= spi_mosi_i;
            mosi_p1 <= mosi_p0;
            cs_n_p0 <= spi_cs_n_i;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_n_p1 & cs_n_p2;
    assign cs_act    = ~cs_n_p1;
    assign rx_byte   = {rx_shift, mosi_p1};

    // Receive shifter holds only the seven earlier bits; the eighth comes straight from mosi_p1
    always_ff @(posedge clk_i) begin
        if (sclk_rise && cs_act) begin
            rx_shift <= rx_byte[DATA_W-2:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt         <= '0;
            spi_byte_vld_o  <= 1'b0;
            spi_byte_data_o <= '0;
        end else begin
            spi_byte_vld_o <= 1'b0;
            if (!cs_act) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    spi_byte_vld_o  <= 1'b1;
                    spi_byte_data_o <= rx_byte;
                end
            end
        end
    end

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_W-1:0] tx_shift;

    // A fall with the counter at 0 follows a completed byte: fetch the next byte to send
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift <= '0;
        end else if (cs_fall) begin
            tx_shift <= spi_byte_data_i;
        end else if (cs_act && sclk_fall) begin
            if (bit_cnt == '0) begin
                tx_shift <= spi_byte_data_i;
            end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign spi_miso_o = tx_shift[DATA_W-1];
`else
    logic unused_byte_data;

    assign unused_byte_data = ^spi_byte_data_i;
    assign spi_miso_o       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, rx scoreboard queue, MISO capture.
`timescale 1ns/1ps

module tb_spi_slave;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] spi_byte_data_i;
    logic       spi_sclk_i = 1'b0;
    logic       spi_mosi_i = 1'b0;
    logic       spi_cs_n_i = 1'b1;
    logic       spi_miso_o;
    logic       spi_byte_vld_o;
    logic [7:0] spi_byte_data_o;

    int         checks = 0;
    int         errors = 0;
    int         vld_total = 0;
    int         vld_mark = 0;
    logic       prev_vld = 1'b0;
    realtime    last_rise_t = 0.0;
    logic [7:0] exp_q[$];
`ifdef SPI_SLAVE_MISO_EN
    int         tx_idx = 0;
`endif

    // Consumer model: starts at 0x6E and steps by one on every received byte
    assign spi_byte_data_i = 8'h6E + 8'(vld_total - vld_mark);

    spi_slave dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .spi_byte_data_i (spi_byte_data_i),
        .spi_sclk_i      (spi_sclk_i),
        .spi_mosi_i      (spi_mosi_i),
        .spi_cs_n_i      (spi_cs_n_i),
        .spi_miso_o      (spi_miso_o),
        .spi_byte_vld_o  (spi_byte_vld_o),
        .spi_byte_data_o (spi_byte_data_o)
    );

    always #2.5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One SCLK period is 6 clk_i cycles (30 ns); MISO is captured just before each rise
    task automatic send(input logic [7:0] b, input int nbits, input bit chk_tx);
        logic [7:0] m;
        m = 8'h00;
        if (nbits == 8 && spi_cs_n_i == 1'b0) exp_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = b[3'(7 - i)];
            clks(3);
            m = {m[6:0], spi_miso_o};
            spi_sclk_i  = 1'b1;
            last_rise_t = $realtime;
            clks(3);
            spi_sclk_i = 1'b0;
        end
        if (nbits == 8) begin
`ifdef SPI_SLAVE_MISO_EN
            if (chk_tx) begin
                check("miso_byte", 32'(m), 32'(8'h6E + 8'(tx_idx)));
                tx_idx++;
            end
`else
            check(chk_tx ? "miso_zero_tx" : "miso_zero", 32'(m), 32'h0);
`endif
        end
    endtask

    always @(negedge clk_i) begin
        if (spi_byte_vld_o === 1'b1) begin
            check("vld_width", 32'(prev_vld), 32'h0);
            check("vld_latency", 32'(($realtime - last_rise_t) < 22.0), 32'h1);
            check("vld_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) check("rx_data", 32'(spi_byte_data_o), 32'(exp_q.pop_front()));
            vld_total <= vld_total + 1;
        end
        prev_vld <= spi_byte_vld_o;
    end

    initial begin
        rst_i = 1'b1;
        clks(3);
        check("reset_vld", 32'(spi_byte_vld_o), 32'h0);
        check("reset_data", 32'(spi_byte_data_o), 32'h0);
        check("reset_miso", 32'(spi_miso_o), 32'h0);
        rst_i = 1'b0;
        clks(4);

        spi_cs_n_i = 1'b0;
        clks(6);
        send(8'h2A, 8, 1'b0);
        send(8'h2B, 8, 1'b0);
        for (int k = 0; k < 128; k++) send(8'h00, 8, 1'b0);
        clks(3);
        spi_cs_n_i = 1'b1;
        clks(6);
        for (int k = 0; k < 4; k++) send(8'hFF, 8, 1'b0);
        clks(10);
        check("vld_count_frame", 32'(vld_total), 32'd130);

        vld_mark = vld_total;
        clks(2);
        spi_cs_n_i = 1'b0;
        clks(6);
        send(8'h11, 8, 1'b1);
        send(8'h22, 8, 1'b1);
        send(8'h33, 8, 1'b1);
        clks(3);
        spi_cs_n_i = 1'b1;
        clks(10);
        check("rx_hold", 32'(spi_byte_data_o), 32'h33);

        spi_cs_n_i = 1'b0;
        clks(6);
        send(8'hFF, 5, 1'b0);
        clks(3);
        spi_cs_n_i = 1'b1;
        clks(6);
        spi_cs_n_i = 1'b0;
        clks(6);
        send(8'hA5, 8, 1'b0);
        clks(10);
        spi_cs_n_i = 1'b1;
        clks(6);
        check("vld_count_abort", 32'(vld_total), 32'd134);

        spi_cs_n_i = 1'b0;
        clks(6);
        send(8'hFF, 4, 1'b0);
        rst_i = 1'b1;
        clks(2);
        check("midreset_vld", 32'(spi_byte_vld_o), 32'h0);
        check("midreset_data", 32'(spi_byte_data_o), 32'h0);
        check("midreset_miso", 32'(spi_miso_o), 32'h0);
        clks(2);
        rst_i = 1'b0;
        clks(6);
        send(8'h3C, 8, 1'b0);
        clks(10);
        spi_cs_n_i = 1'b1;
        clks(10);

        check("vld_count_total", 32'(vld_total), 32'd135);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_data", 32'(spi_byte_data_o), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
